// File: rtl/apb_rr_master_if.sv
// APB bus bundle between the round-robin master and its single slave.
interface apb_rr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W/8-1:0] PSTRB;
  logic                PREADY;
  logic [DATA_W-1:0]   PRDATA;
  logic                PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ requesters onto one APB slave,
// runs SETUP/ACCESS with a PREADY timeout, and returns a one-cycle done pulse.
//
// state  | meaning
// IDLE   | no transfer; pick next eligible requester from rr pointer
// SETUP  | PSEL=1, PENABLE=0; payload latched
// ACCESS | PSEL=1, PENABLE=1; wait for PREADY or timeout
module apb_rr_master #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_strb,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [DATA_W-1:0]            req_rdata,
  output logic                         req_err,
  apb_rr_master_if.master              apb
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_q, state_d;
  logic               psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d, rdata_d;
  logic [STRB_W-1:0]  pstrb_q, pstrb_d;
  logic [NUM_REQ-1:0] done_d, eligible;
  logic               err_d, found;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   grant_q, grant_d, rr_q, rr_d, win, idx;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [STRB_W-1:0]  strb_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    assign strb_arr[g]  = req_strb[g*STRB_W +: STRB_W];
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    done_d    = '0;
    rdata_d   = req_rdata;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    found     = 1'b0;
    win       = '0;
    idx       = '0;
    // A requester in its done cycle is masked so a still-high valid is not re-granted.
    eligible  = req_valid & ~req_done;

    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i >= NUM_REQ) ? PTR_W'(int'(rr_q) + i - NUM_REQ)
                                        : PTR_W'(int'(rr_q) + i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = win;
          rr_d     = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
          pwrite_d = req_write[win];
          paddr_d  = addr_arr[win];
          pwdata_d = req_write[win] ? wdata_arr[win] : '0;
          pstrb_d  = req_write[win] ? strb_arr[win] : '0;
          psel_d   = 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (apb.PREADY) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          done_d[grant_q] = 1'b1;
          rdata_d         = pwrite_q ? '0 : apb.PRDATA;
          err_d           = apb.PSLVERR;
          state_d         = IDLE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          done_d[grant_q] = 1'b1;
          rdata_d         = '0;
          err_d           = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      req_done  <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;
      cnt_q     <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      req_done  <= done_d;
      req_rdata <= rdata_d;
      req_err   <= err_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
    end
  end
endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_apb_rr_master;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic [NR-1:0]    req_valid, req_write, req_done, hold;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*SW-1:0] req_strb;
  logic [DW-1:0]    req_rdata;
  logic             req_err;

  apb_rr_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_rr_master #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .apb(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave memory: word-indexed by PADDR[7:0], mem[i]=i initially.
  logic [31:0] mem [256];
  assign bus.PRDATA = mem[bus.PADDR[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    forever begin
      @(posedge PCLK);
      if (PRESETn && bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
        for (int b = 0; b < SW; b++)
          if (bus.PSTRB[b]) mem[bus.PADDR[7:0]][8*b +: 8] = bus.PWDATA[8*b +: 8];
    end
  end

  // Reference model: one transfer record, timestamped by cycles since grant.
  logic          m_busy, m_write, m_err;
  int            m_t, m_g, m_ptr, m_i;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_strb;
  logic [NR-1:0] m_done, prev_done, elig;

  initial begin
    forever begin
      @(posedge PCLK or negedge PRESETn);
      if (!PRESETn) begin
        m_busy = 0; m_write = 0; m_err = 0; m_t = 0; m_g = 0; m_ptr = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_strb = '0; m_done = '0;
      end else begin
        prev_done = m_done;
        m_done = '0;
        m_err = 1'b0;
        if (!m_busy) begin
          elig = req_valid & ~prev_done;
          for (int k = 0; k < NR; k++) begin
            m_i = (m_ptr + k) % NR;
            if (!m_busy && elig[m_i]) begin
              m_busy  = 1; m_t = 0; m_g = m_i;
              m_write = req_write[m_i];
              m_addr  = req_addr[m_i*AW +: AW];
              m_wdata = m_write ? req_wdata[m_i*DW +: DW] : '0;
              m_strb  = m_write ? req_strb[m_i*SW +: SW] : '0;
              m_ptr   = (m_i + 1) % NR;
            end
          end
        end else if (m_t == 0) begin
          m_t = 1;
        end else if (bus.PREADY) begin
          m_done[m_g] = 1'b1;
          m_rdata = m_write ? '0 : bus.PRDATA;
          m_err = bus.PSLVERR;
          m_busy = 0;
        end else if (m_t == TO) begin
          m_done[m_g] = 1'b1;
          m_rdata = '0;
          m_err = 1'b1;
          m_busy = 0;
        end else begin
          m_t++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        chk("PSEL",      64'(bus.PSEL),    64'(m_busy));
        chk("PENABLE",   64'(bus.PENABLE), 64'(m_busy && m_t >= 1));
        chk("PWRITE",    64'(bus.PWRITE),  64'(m_write));
        chk("PADDR",     64'(bus.PADDR),   64'(m_addr));
        chk("PWDATA",    64'(bus.PWDATA),  64'(m_wdata));
        chk("PSTRB",     64'(bus.PSTRB),   64'(m_strb));
        chk("req_done",  64'(req_done),    64'(m_done));
        chk("req_rdata", 64'(req_rdata),   64'(m_rdata));
        chk("req_err",   64'(req_err),     64'(m_err));
        if (req_done != '0) n_done_seen++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge PCLK);
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_done[i] && !hold[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[r] = w;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_strb[r*SW +: SW] = s;
    req_valid[r] = 1'b1;
  endtask

  task automatic do_req(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int cyc, output logic [31:0] rd,
                        output logic er, output logic [3:0] strb_seen, output int psel_n,
                        output int pen_n, output logic [1:0] ctl);
    set_req(r, w, a, d, s);
    cyc = 0; rd = '0; er = 0; strb_seen = '0; psel_n = 0; pen_n = 0; ctl = '1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.PSEL) begin psel_n++; strb_seen |= bus.PSTRB; end
      if (bus.PENABLE) pen_n++;
      if (req_done[r]) begin
        cyc = c; rd = req_rdata; er = req_err; ctl = {bus.PSEL, bus.PENABLE};
        break;
      end
    end
  endtask

  task automatic rand_step(input int ready_pct);
    int r;
    bus.PREADY  = ($urandom_range(99) < ready_pct);
    bus.PSLVERR = ($urandom_range(99) < 20);
    for (int i = 0; i < NR; i++) begin
      r = int'($urandom_range(99));
      if (!req_valid[i]) begin
        if (r < 30) set_req(i, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
      end else if (r < 8) begin
        req_addr[i*AW +: AW] = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
      end else if (r < 11) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  int          cyc, psel_n, pen_n, first, c_first, c_last, nd, bad;
  logic [31:0] rd;
  logic        er, got;
  logic [3:0]  sseen;
  logic [1:0]  ctl;
  int          order [4];

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; hold = '0;
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    repeat (3) tick();
    #2 PRESETn = 1'b1;
    tick();

    chk("rst_PSEL",    64'(bus.PSEL), 64'(0));
    chk("rst_PENABLE", 64'(bus.PENABLE), 64'(0));
    chk("rst_PADDR",   64'(bus.PADDR), 64'(0));
    chk("rst_PWDATA",  64'(bus.PWDATA), 64'(0));
    chk("rst_PSTRB",   64'(bus.PSTRB), 64'(0));
    chk("rst_done",    64'(req_done), 64'(0));
    chk("rst_rdata",   64'(req_rdata), 64'(0));
    chk("rst_err",     64'(req_err), 64'(0));

    // Basic read
    do_req(0, 1'b0, 32'd5, 32'h0, 4'h0, cyc, rd, er, sseen, psel_n, pen_n, ctl);
    chk("rd5_latency", 64'(cyc), 64'(3));
    chk("rd5_psel_cycles", 64'(psel_n), 64'(2));
    chk("rd5_rdata", 64'(rd), 64'h5);
    chk("rd5_err", 64'(er), 64'(0));

    // Strobed write then read-back
    tick();
    do_req(1, 1'b1, 32'd3, 32'hAABBCCDD, 4'b0101, cyc, rd, er, sseen, psel_n, pen_n, ctl);
    chk("wr3_latency", 64'(cyc), 64'(3));
    chk("wr3_strb", 64'(sseen), 64'(4'b0101));
    chk("wr3_rdata", 64'(rd), 64'(0));
    tick();
    do_req(1, 1'b0, 32'd3, 32'h12345678, 4'hF, cyc, rd, er, sseen, psel_n, pen_n, ctl);
    chk("rd3_strb_zero", 64'(sseen), 64'(0));
    chk("rd3_rdata", 64'(rd), 64'h00BB00DD);

    // Slave error is passed through
    tick();
    bus.PSLVERR = 1'b1;
    do_req(2, 1'b0, 32'd4, 32'h0, 4'h0, cyc, rd, er, sseen, psel_n, pen_n, ctl);
    bus.PSLVERR = 1'b0;
    chk("slverr_err", 64'(er), 64'(1));
    chk("slverr_rdata", 64'(rd), 64'h4);

    // Fairness with req0 and req1 both held
    tick();
    hold = 3'b011;
    set_req(0, 1'b0, 32'd1, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'd2, 32'h0, 4'h0);
    nd = 0; c_first = 0; c_last = 0;
    for (int c = 1; c <= 100 && nd < 4; c++) begin
      tick();
      if (req_done != '0) begin
        order[nd] = req_done[1] ? 1 : (req_done[0] ? 0 : 2);
        if (nd == 0) c_first = c;
        c_last = c;
        nd++;
      end
    end
    hold = '0;
    req_valid = '0;
    chk("rr_count", 64'(nd), 64'(4));
    chk("rr_order0", 64'(order[0]), 64'(0));
    chk("rr_order1", 64'(order[1]), 64'(1));
    chk("rr_order2", 64'(order[2]), 64'(0));
    chk("rr_order3", 64'(order[3]), 64'(1));
    chk("rr_spacing", 64'(c_last - c_first), 64'(9));

    // PREADY timeout
    tick(); tick();
    bus.PREADY = 1'b0;
    do_req(0, 1'b0, 32'd7, 32'h0, 4'h0, cyc, rd, er, sseen, psel_n, pen_n, ctl);
    bus.PREADY = 1'b1;
    chk("to_access_cycles", 64'(pen_n), 64'(16));
    chk("to_latency", 64'(cyc), 64'(18));
    chk("to_err", 64'(er), 64'(1));
    chk("to_rdata", 64'(rd), 64'(0));
    chk("to_ctl", 64'(ctl), 64'(0));

    // Payload captured at grant; valid dropped and address changed in flight
    tick();
    set_req(0, 1'b0, 32'd9, 32'h0, 4'h0);
    tick();
    chk("cap_granted", 64'(bus.PSEL), 64'(1));
    req_valid[0] = 1'b0;
    req_addr[0 +: AW] = 32'h44;
    bad = 0; got = 0; rd = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.PSEL && bus.PADDR != 32'd9) bad++;
      if (req_done[0]) begin got = 1; rd = req_rdata; break; end
    end
    chk("cap_paddr_stable", 64'(bad), 64'(0));
    chk("cap_done", 64'(got), 64'(1));
    chk("cap_rdata", 64'(rd), 64'd9);

    // Reset during ACCESS of a write
    tick();
    bus.PREADY = 1'b0;
    set_req(0, 1'b1, 32'd10, 32'hDEADBEEF, 4'hF);
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.PENABLE) begin got = 1; break; end
    end
    chk("rst_mid_access_reached", 64'(got), 64'(1));
    tick();
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_PSEL", 64'(bus.PSEL), 64'(0));
    chk("rst_mid_PENABLE", 64'(bus.PENABLE), 64'(0));
    chk("rst_mid_done", 64'(req_done), 64'(0));
    req_valid = '0;
    bus.PREADY = 1'b1;
    tick(); tick();
    #2 PRESETn = 1'b1;
    tick();
    set_req(0, 1'b0, 32'd10, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'd11, 32'h0, 4'h0);
    first = -1; cyc = 0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (req_done != '0) begin first = req_done[0] ? 0 : 1; cyc = c; rd = req_rdata; break; end
    end
    chk("post_rst_first", 64'(first), 64'(0));
    chk("post_rst_latency", 64'(cyc), 64'(3));
    chk("post_rst_rdata", 64'(rd), 64'd10);
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (req_done[1]) begin got = 1; rd = req_rdata; break; end
    end
    chk("post_rst_req1", 64'(got), 64'(1));
    chk("post_rst_req1_rdata", 64'(rd), 64'd11);

    // Randomized traffic
    nd = n_done_seen;
    for (int n = 0; n < 2500; n++) begin tick(); rand_step(75); end
    for (int n = 0; n < 1000; n++) begin tick(); rand_step(5); end
    req_valid = '0;
    bus.PREADY = 1'b1;
    bus.PSLVERR = 1'b0;
    repeat (40) tick();
    chk("rand_activity", 64'(n_done_seen - nd > 200), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
